// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// SYSTOLIC_SAT_EN selects saturating instead of wrapping output reduction.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    function automatic int acc_width(input int din_w, input int k_max);
        return 2 * din_w + $clog2(k_max);
    endfunction

    // Cycles from the last accepted beat until the far-corner PE has its final sum.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    function automatic logic signed [63:0] reduce_acc(input logic signed [63:0] acc,
                                                      input int unsigned out_w);
`ifdef SYSTOLIC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return acc & ((64'sd1 <<< out_w) - 64'sd1);
`endif
    endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// Output-stationary MAC cell: forwards A right and B down, accumulates in place.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DIN_W = 8,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIN_W-1:0]        a_i,
    input  logic [DIN_W-1:0]        b_i,
    input  logic                    v_i,
    input  logic                    clr_i,
    output logic [DIN_W-1:0]        a_o,
    output logic [DIN_W-1:0]        b_o,
    output logic                    v_o,
    output logic                    clr_o,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*DIN_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod     = (2*DIN_W)'($signed(a_i)) * (2*DIN_W)'($signed(b_i));
    assign prod_ext = ACC_W'(prod);
    assign acc_o    = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o   <= '0;
            b_o   <= '0;
            v_o   <= 1'b0;
            clr_o <= 1'b0;
            acc_q <= '0;
        end else begin
            a_o   <= a_i;
            b_o   <= b_i;
            v_o   <= v_i;
            clr_o <= clr_i;
            if (v_i) acc_q <= clr_i ? prod_ext : acc_q + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// ROWS x COLS output-stationary systolic matmul: skewed operand injection, FSM, row drain.
// Define SYSTOLIC_SAT_EN for saturating C outputs; default build wraps.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int DIN_W = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_MAX = 16,
    parameter int OUT_W = 2 * DIN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(K_MAX):0]    k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*DIN_W-1:0]     a_din,
    input  logic [COLS*DIN_W-1:0]     b_din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*OUT_W-1:0]     c_out,
    output logic [$clog2(ROWS)-1:0]   out_row,
    output logic                      out_last,
    output logic                      busy
);

    localparam int ACC_W   = acc_width(DIN_W, K_MAX);
    localparam int KW      = $clog2(K_MAX) + 1;
    localparam int RW      = $clog2(ROWS);
    localparam int FLUSH_N = flush_len(ROWS, COLS);
    localparam int FW      = $clog2(FLUSH_N) + 1;

    state_t                   state_q;
    logic [KW-1:0]            k_q, cnt_q, k_eff;
    logic [FW-1:0]            fl_q;
    logic [RW-1:0]            row_q, sel_row;
    logic                     in_ready_q, out_valid_q, out_last_q, busy_q;
    logic [COLS*OUT_W-1:0]    c_out_q, c_row_d;
    logic signed [63:0]       red;
    logic                     accept;

    logic [DIN_W-1:0]         a_h   [ROWS][COLS+1];
    logic                     v_h   [ROWS][COLS+1];
    logic                     clr_h [ROWS][COLS+1];
    logic [DIN_W-1:0]         b_v   [ROWS+1][COLS];
    logic signed [ACC_W-1:0]  acc   [ROWS][COLS];

    assign accept    = in_valid && in_ready_q;
    assign k_eff     = (k_len == '0) ? KW'(1) : k_len;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c_out     = c_out_q;
    assign out_row   = row_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    // Row i of A (with its valid/clr tags) is delayed i cycles before entering column 0.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [DIN_W+1:0] lane;
        assign lane = {accept && (state_q == IDLE), accept, a_din[i*DIN_W +: DIN_W]};
        if (i == 0) begin : g_nodly
            assign {clr_h[i][0], v_h[i][0], a_h[i][0]} = lane;
        end else begin : g_dly
            logic [DIN_W+1:0] sr_q [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned s = 0; s < i; s++) sr_q[s] <= '0;
                end else begin
                    sr_q[0] <= lane;
                    for (int unsigned s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign {clr_h[i][0], v_h[i][0], a_h[i][0]} = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        if (j == 0) begin : g_nodly
            assign b_v[0][j] = b_din[j*DIN_W +: DIN_W];
        end else begin : g_dly
            logic [DIN_W-1:0] sr_q [j];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned s = 0; s < j; s++) sr_q[s] <= '0;
                end else begin
                    sr_q[0] <= b_din[j*DIN_W +: DIN_W];
                    for (int unsigned s = 1; s < j; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign b_v[0][j] = sr_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_mac_pe #(.DIN_W(DIN_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .a_i   (a_h[i][j]),
                .b_i   (b_v[i][j]),
                .v_i   (v_h[i][j]),
                .clr_i (clr_h[i][j]),
                .a_o   (a_h[i][j+1]),
                .b_o   (b_v[i+1][j]),
                .v_o   (v_h[i][j+1]),
                .clr_o (clr_h[i][j+1]),
                .acc_o (acc[i][j])
            );
        end
    end

    // Selects the row to present next: row 0 on DRAIN entry, otherwise the row after the current one.
    always_comb begin
        sel_row = (out_valid_q && !out_last_q) ? row_q + RW'(1) : '0;
        c_row_d = '0;
        red     = '0;
        for (int unsigned j = 0; j < COLS; j++) begin
            red = reduce_acc(64'(acc[sel_row][j]), OUT_W);
            c_row_d[j*OUT_W +: OUT_W] = red[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            fl_q        <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            c_out_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    k_q    <= k_eff;
                    cnt_q  <= KW'(1);
                    fl_q   <= '0;
                    busy_q <= 1'b1;
                    if (k_eff == KW'(1)) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                LOAD: if (accept) begin
                    cnt_q <= cnt_q + KW'(1);
                    if (cnt_q + KW'(1) == k_q) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                        fl_q       <= '0;
                    end
                end
                FLUSH: begin
                    if (fl_q == FW'(FLUSH_N - 1)) state_q <= DRAIN;
                    else                          fl_q    <= fl_q + FW'(1);
                end
                DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        c_out_q     <= c_row_d;
                        row_q       <= '0;
                        out_last_q  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            row_q       <= '0;
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            row_q      <= row_q + RW'(1);
                            c_out_q    <= c_row_d;
                            out_last_q <= (row_q + RW'(1) == RW'(ROWS - 1));
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine (default 4x4, DIN_W=8, OUT_W=16).
module tb_systolic_mm_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  k_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_din;
    logic [31:0] b_din;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] c_out;
    logic [1:0]  out_row;
    logic        out_last;
    logic        busy;

    systolic_mm_engine #(.DIN_W(8), .ROWS(4), .COLS(4), .K_MAX(16), .OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_din     (a_din),
        .b_din     (b_din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] c;
        logic [1:0]  row;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_acc;
    int          lat_exp;
    bit          lat_armed = 1'b0;
    int          ready_mode = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_c;
    logic [1:0]  prev_row;
    int          job_a [16][4];
    int          job_b [16][4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] red16(input int v);
`ifdef SYSTOLIC_SAT_EN
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(1, 0));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_c", c_out, prev_c);
                check("stall_row", 64'(out_row), 64'(prev_row));
                check("stall_valid", 64'(out_valid), 64'd1);
            end
            if (out_valid && lat_armed) begin
                check("latency", 64'(cyc), 64'(lat_exp));
                lat_armed = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("c_row", c_out, e.c);
                    check("out_row", 64'(out_row), 64'(e.row));
                    check("out_last", 64'(out_last), 64'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c_out;
            prev_row   = out_row;
        end
    end

    task automatic send_job(input int k, input int kl, input bit gaps, input int nsend, input bit push);
        if (push) begin
            for (int r = 0; r < 4; r++) begin
                exp_t e;
                e.c = '0;
                for (int j = 0; j < 4; j++) begin
                    int s = 0;
                    for (int b = 0; b < k; b++) s += job_a[b][r] * job_b[b][j];
                    e.c[j*16 +: 16] = red16(s);
                end
                e.row  = 2'(r);
                e.last = (r == 3);
                sb.push_back(e);
            end
        end
        for (int b = 0; b < nsend; b++) begin
            bit acc_ok = 1'b0;
            int t = 0;
            if (gaps) begin
                for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                a_din[i*8 +: 8] = 8'(job_a[b][i]);
                b_din[i*8 +: 8] = 8'(job_b[b][i]);
            end
            k_len = (b == 0 || !gaps) ? 5'(kl) : 5'($urandom_range(16, 0));
            while (!acc_ok && t < 100) begin
                @(negedge clk);
                if (in_ready) begin
                    acc_ok = 1'b1;
                    if (b == 0) first_acc = cyc;
                end
                @(posedge clk); #1;
                t++;
            end
            if (!acc_ok) check("accept_timeout", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) check("done_timeout", 64'(sb.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_c_out"}, c_out, 64'd0);
        check({tag, "_out_row"}, 64'(out_row), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic fill_random(input int k);
        for (int b = 0; b < k; b++)
            for (int i = 0; i < 4; i++) begin
                job_a[b][i] = int'($urandom_range(255, 0)) - 128;
                job_b[b][i] = int'($urandom_range(255, 0)) - 128;
            end
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        sb.delete();
        lat_armed = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; k_len = '0; a_din = '0; b_din = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity A: C rows equal B rows; exact first-output latency.
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++) begin
                job_a[b][i] = (b == i) ? 1 : 0;
                job_b[b][i] = b * 4 + i;
            end
        send_job(4, 4, 1'b0, 4, 1'b1);
        lat_exp = first_acc + 12; lat_armed = 1'b1;
        wait_done();

        // Single-beat job: 3 * -2, in_ready held low through the flush.
        for (int i = 0; i < 4; i++) begin job_a[0][i] = 3; job_b[0][i] = -2; end
        send_job(1, 1, 1'b0, 1, 1'b1);
        lat_exp = first_acc + 9; lat_armed = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("flush_in_ready", 64'(in_ready), 64'd0);
            check("flush_busy", 64'(busy), 64'd1);
        end
        wait_done();

        // Full depth with the most negative operand: 262144 wraps or saturates.
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 4; i++) begin job_a[b][i] = -128; job_b[b][i] = -128; end
        send_job(16, 16, 1'b0, 16, 1'b1);
        wait_done();

        // Random gaps, random backpressure, random data, k_len perturbed mid-job.
        ready_mode = 1;
        for (int n = 0; n < 3; n++) begin
            fill_random(7);
            send_job(7, 7, 1'b1, 7, 1'b1);
            wait_done();
        end

        // Back-to-back jobs; the second must carry no residue from the first.
        fill_random(3);
        send_job(3, 3, 1'b0, 3, 1'b1);
        fill_random(5);
        send_job(5, 5, 1'b1, 5, 1'b1);
        wait_done();
        ready_mode = 0;

        // Abort mid-LOAD, then a clean job.
        fill_random(4);
        send_job(4, 4, 1'b0, 2, 1'b0);
        pulse_reset("rst_load");
        fill_random(4);
        send_job(4, 4, 1'b0, 4, 1'b1);
        wait_done();

        // Abort mid-DRAIN while stalled, then a clean job.
        ready_mode = 2;
        fill_random(2);
        send_job(2, 2, 1'b0, 2, 1'b1);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
            if (t >= 100) check("drain_timeout", 64'(out_valid), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        pulse_reset("rst_drain");
        ready_mode = 0;
        fill_random(6);
        send_job(6, 0, 1'b0, 0, 1'b0);
        fill_random(6);
        send_job(6, 6, 1'b0, 6, 1'b1);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised output-stationary ROWS x COLS systolic matrix-multiply engine; the successor to the fixed N x N array.
- Accepts one A column vector (ROWS elements) and one B row vector (COLS elements) per beat, over a runtime-selected depth of K beats, using a valid/ready handshake.
- Skews operands internally and accumulates C = A x B in place.
- Drains the result one C row per beat with backpressure; sits between operand buffers and the result writeback path.

Parameters:
- DIN_W, 8, signed operand width.
- ROWS, 4, PE rows (A elements per beat, C rows), >=2.
- COLS, 4, PE columns (B elements per beat, C columns), >=2.
- K_MAX, 16, maximum accumulation depth, power of 2.
- OUT_W, 2*DIN_W, width of each C output element.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- k_len  in  $clog2(K_MAX)+1  job depth; sampled with the first accepted beat
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts a beat
- a_din  in  ROWS x DIN_W signed  A column k
- b_din  in  COLS x DIN_W signed  B row k
- out_valid  out  1  C row valid
- out_ready  in  1  sink accepts the C row
- c_out  out  COLS x OUT_W signed  C row elements
- out_row  out  $clog2(ROWS)  index of the presented C row
- out_last  out  1  asserted on row ROWS-1
- busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=1, out_valid=0, c_out=0, out_row=0, out_last=0, busy=0, all PE and skew registers 0, state=IDLE.
- Accumulator width: ACC_W = 2*DIN_W + $clog2(K_MAX); full-precision signed multiply-accumulate, no overflow possible for k_len <= K_MAX.
- Handshake: a beat transfers when in_valid && in_ready. Gaps of any length between beats are legal.
- A valid bit and a clr bit travel with the skewed data. A PE accumulates only when its valid bit is set. On the first beat of a job, clr=1 and the PE loads the product instead of adding it.
- Skew: A row i is delayed i cycles; B column j is delayed j cycles.
- IDLE: in_ready=1. An accepted beat latches k_len (0 is treated as 1), sets beat count to 1, then goes to LOAD, or straight to FLUSH if the latched length is 1.
- LOAD: in_ready=1. Each accepted beat increments the count. The beat making count == k_len moves to FLUSH.
- FLUSH: in_ready=0 for exactly ROWS+COLS-1 cycles, counted from the cycle after the last accept, then DRAIN.
- DRAIN: in_ready=0. Rows are read from the PE accumulators via a mux.
  - c_out element j = PE(r,j) accumulator, reduced to OUT_W; out_row=r.
  - out_valid=1 is registered. Outputs must stay stable while out_valid && !out_ready.
  - r advances on out_valid && out_ready. The handshake with r == ROWS-1 (out_last=1) deasserts out_valid and returns to IDLE.
  - First DRAIN output is visible 1 cycle after entering DRAIN.
- Without the optional feature, the reduction to OUT_W keeps the low OUT_W bits (wraps).
- k_len changes mid-job are ignored.
- in_valid during FLUSH/DRAIN is not accepted and is held off by in_ready=0.
- rst_n assertion at any point aborts the job immediately and returns every output to its reset value. The next job needs no extra clear.

Optional Feature:
- Macro: SYSTOLIC_SAT_EN.
- Defined: each c_out element saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when the accumulator is out of range.
- Undefined: truncation/wrap as stated in Behaviour. Both builds have identical latency and ports.

Decomposition:
- Package systolic_pkg: state_t enum {IDLE, LOAD, FLUSH, DRAIN}, ACC_W calculation function, FLUSH length constant expression, saturation/truncation function (macro-guarded body).
- Sub-module systolic_mac_pe: a/b pass-through registers, valid/clr pass-through, ACC_W accumulator.
- The engine instantiates the PE grid, skew shift registers, FSM and drain mux.

Test Plan:
- 4x4, k_len=4, A=identity, B[k][j]=k*4+j, continuous valid, out_ready=1 -> rows 0..3 equal B rows, out_last on row 3, first out_valid exactly 4+(4+4-1)+1 cycles after the first accept.
- k_len=1, a_din all 3, b_din all -2 -> every c_out element = -6; in_ready low for 7 cycles after the accept.
- k_len=16, all operands -128 -> each element = 262144; wraps to 0 at OUT_W=16 without the macro, saturates to 32767 with SYSTOLIC_SAT_EN.
- Random in_valid gaps (50%) plus random out_ready stalls, random signed data, k_len=7 -> results match a golden model; c_out/out_row stable throughout stalls.
- Back-to-back jobs with different data, k_len=3 then 5 -> second result has no residue from the first (clr works).
- rst_n pulsed mid-LOAD and mid-DRAIN -> outputs return to reset values that cycle; the next job gives correct results.
